// File: rtl/svc_rv_bpred_upd.sv
// Branch-prediction EX/MEM back end: MEM-stage misprediction/redirect and a
// coalescing FIFO of BTB training updates with saturating statistics.
module svc_rv_bpred_upd #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 4,
    parameter int RET_MODE = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             is_branch_ex,
    input  logic             is_jal_ex,
    input  logic             is_jalr_ex,
    input  logic [4:0]       rd_ex,
    input  logic [4:0]       rs1_ex,
    input  logic             bpred_taken_ex,
    input  logic             branch_taken_ex,
    input  logic [XLEN-1:0]  pc_ex,
    input  logic [XLEN-1:0]  jb_target_ex,
    input  logic [XLEN-1:0]  pred_target_ex,
    output logic             mispredicted_mem,
    output logic [XLEN-1:0]  redirect_pc_mem,
    output logic             btb_upd_valid,
    input  logic             btb_upd_ready,
    output logic [XLEN-1:0]  btb_upd_pc,
    output logic [XLEN-1:0]  btb_upd_target,
    output logic             btb_upd_taken,
    output logic             btb_upd_is_return,
    output logic             upd_full,
    output logic [CNT_W-1:0] mispred_cnt,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic            valid;
        logic            is_branch;
        logic            is_jal;
        logic            is_jalr;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic            bpred_taken;
        logic            branch_taken;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] jb_target;
        logic [XLEN-1:0] pred_target;
    } slot_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
        logic            taken;
        logic            is_ret;
    } ent_t;

    slot_t            slot_d, slot_q;
    ent_t             mem_d [DEPTH];
    ent_t             mem_q [DEPTH];
    ent_t             new_ent, head;
    logic [AW:0]      wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
    logic [AW-1:0]    wr_idx, rd_idx, last_idx;
    logic [CNT_W-1:0] mis_cnt_d, mis_cnt_q, drop_cnt_d, drop_cnt_q;
    logic             ret_rs1_ok, is_ret, taken_act, is_cfi, mispred, predictable;
    logic             empty, full, pop, coalesce, push, drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        slot_d              = '0;
        slot_d.valid        = ex_valid;
        slot_d.is_branch    = is_branch_ex;
        slot_d.is_jal       = is_jal_ex;
        slot_d.is_jalr      = is_jalr_ex;
        slot_d.rd           = rd_ex;
        slot_d.rs1          = rs1_ex;
        slot_d.bpred_taken  = bpred_taken_ex;
        slot_d.branch_taken = branch_taken_ex;
        slot_d.pc           = pc_ex;
        slot_d.jb_target    = jb_target_ex;
        slot_d.pred_target  = pred_target_ex;
    end

    // MEM-stage evaluation, all from the registered slot
    assign ret_rs1_ok  = (RET_MODE == 0) || (slot_q.rs1 == 5'd1) || (slot_q.rs1 == 5'd5);
    assign is_ret      = slot_q.is_jalr && (slot_q.rd == 5'd0) && ret_rs1_ok;
    assign taken_act   = (slot_q.is_jal || slot_q.is_jalr) ? 1'b1 : slot_q.branch_taken;
    assign is_cfi      = slot_q.is_branch || slot_q.is_jal || slot_q.is_jalr;
    assign mispred     = slot_q.valid && is_cfi &&
                         ((taken_act != slot_q.bpred_taken) ||
                          (taken_act && slot_q.bpred_taken && (slot_q.jb_target != slot_q.pred_target)));
    assign predictable = slot_q.valid && (slot_q.is_branch || slot_q.is_jal || is_ret);

    assign mispredicted_mem = mispred;
    assign redirect_pc_mem  = !mispred ? '0 :
                              taken_act ? slot_q.jb_target : slot_q.pc + XLEN'(4);

    assign new_ent.pc     = slot_q.pc;
    assign new_ent.target = slot_q.jb_target;
    assign new_ent.taken  = taken_act;
    assign new_ent.is_ret = is_ret;

    assign wr_idx   = wr_ptr_q[AW-1:0];
    assign rd_idx   = rd_ptr_q[AW-1:0];
    assign last_idx = wr_idx - AW'(1);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
    assign pop      = !empty && btb_upd_ready;

    // A repeat of the newest PC refreshes it in place, unless it is leaving as the head
    assign coalesce = predictable && !empty && (mem_q[last_idx].pc == slot_q.pc) &&
                      !(pop && (last_idx == rd_idx));
    assign push     = predictable && !coalesce && (!full || pop);
    assign drop     = predictable && !coalesce && full && !pop;

    always_comb begin
        mem_d = mem_q;
        if (push)     mem_d[wr_idx]   = new_ent;
        if (coalesce) mem_d[last_idx] = new_ent;
        wr_ptr_d   = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        mis_cnt_d  = mispred ? sat_inc(mis_cnt_q) : mis_cnt_q;
        drop_cnt_d = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mis_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            slot_q     <= slot_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mis_cnt_q  <= mis_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head              = empty ? '0 : mem_q[rd_idx];
    assign btb_upd_valid     = !empty;
    assign btb_upd_pc        = head.pc;
    assign btb_upd_target    = head.target;
    assign btb_upd_taken     = head.taken;
    assign btb_upd_is_return = head.is_ret;
    assign upd_full          = full;
    assign mispred_cnt       = mis_cnt_q;
    assign drop_cnt          = drop_cnt_q;
endmodule

// File: tb/tb_svc_rv_bpred_upd.sv
// Scoreboard bench for svc_rv_bpred_upd: redirects and BTB updates are queued
// on issue and checked by a monitor when the DUT presents them.
module tb_svc_rv_bpred_upd;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        taken;
        logic        ret;
    } upd_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ex_valid, is_branch_ex, is_jal_ex, is_jalr_ex;
    logic [4:0]       rd_ex, rs1_ex;
    logic             bpred_taken_ex, branch_taken_ex;
    logic [XLEN-1:0]  pc_ex, jb_target_ex, pred_target_ex;
    logic             mispredicted_mem;
    logic [XLEN-1:0]  redirect_pc_mem;
    logic             btb_upd_valid, btb_upd_ready;
    logic [XLEN-1:0]  btb_upd_pc, btb_upd_target;
    logic             btb_upd_taken, btb_upd_is_return, upd_full;
    logic [CNT_W-1:0] mispred_cnt, drop_cnt;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mis_q[$];
    upd_t        upd_q[$];
    logic [31:0] e_redir;
    upd_t        e_upd;

    localparam logic [2:0] K_NONE = 3'b000, K_BR = 3'b100, K_JAL = 3'b010, K_JALR = 3'b001;

    svc_rv_bpred_upd #(.XLEN(XLEN), .DEPTH(DEPTH), .RET_MODE(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid),
        .is_branch_ex(is_branch_ex), .is_jal_ex(is_jal_ex), .is_jalr_ex(is_jalr_ex),
        .rd_ex(rd_ex), .rs1_ex(rs1_ex),
        .bpred_taken_ex(bpred_taken_ex), .branch_taken_ex(branch_taken_ex),
        .pc_ex(pc_ex), .jb_target_ex(jb_target_ex), .pred_target_ex(pred_target_ex),
        .mispredicted_mem(mispredicted_mem), .redirect_pc_mem(redirect_pc_mem),
        .btb_upd_valid(btb_upd_valid), .btb_upd_ready(btb_upd_ready),
        .btb_upd_pc(btb_upd_pc), .btb_upd_target(btb_upd_target),
        .btb_upd_taken(btb_upd_taken), .btb_upd_is_return(btb_upd_is_return),
        .upd_full(upd_full), .mispred_cnt(mispred_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_upd(input logic [31:0] pc, input logic [31:0] tgt,
                            input logic tk, input logic ret);
        upd_t u;
        u.pc = pc; u.tgt = tgt; u.taken = tk; u.ret = ret;
        upd_q.push_back(u);
    endtask

    task automatic issue(input logic v, input logic [2:0] kind, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic bp, input logic bt,
                         input logic [31:0] pc, input logic [31:0] tgt, input logic [31:0] ptgt,
                         input logic mp, input logic [31:0] redir);
        ex_valid        = v;
        is_branch_ex    = kind[2];
        is_jal_ex       = kind[1];
        is_jalr_ex      = kind[0];
        rd_ex           = rd;
        rs1_ex          = rs1;
        bpred_taken_ex  = bp;
        branch_taken_ex = bt;
        pc_ex           = pc;
        jb_target_ex    = tgt;
        pred_target_ex  = ptgt;
        if (mp) mis_q.push_back(redir);
        @(posedge clk);
        #1;
        ex_valid     = 1'b0;
        is_branch_ex = 1'b0;
        is_jal_ex    = 1'b0;
        is_jalr_ex   = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mispredicted_mem) begin
                if (mis_q.size() == 0) chk("mispred_unexpected", 32'(mispredicted_mem), 32'd0);
                else begin
                    e_redir = mis_q.pop_front();
                    chk("redirect_pc", redirect_pc_mem, e_redir);
                end
            end else begin
                chk("redirect_idle", redirect_pc_mem, 32'd0);
            end
            if (btb_upd_valid && btb_upd_ready) begin
                if (upd_q.size() == 0) chk("upd_unexpected", 32'(btb_upd_valid), 32'd0);
                else begin
                    e_upd = upd_q.pop_front();
                    chk("upd_pc", btb_upd_pc, e_upd.pc);
                    chk("upd_target", btb_upd_target, e_upd.tgt);
                    chk("upd_taken", 32'(btb_upd_taken), 32'(e_upd.taken));
                    chk("upd_is_return", 32'(btb_upd_is_return), 32'(e_upd.ret));
                end
            end
        end
    end

    initial begin
        logic [31:0] pc;
        ex_valid = 0; is_branch_ex = 0; is_jal_ex = 0; is_jalr_ex = 0;
        rd_ex = 0; rs1_ex = 0; bpred_taken_ex = 0; branch_taken_ex = 0;
        pc_ex = 0; jb_target_ex = 0; pred_target_ex = 0;
        btb_upd_ready = 1'b1;
        idle(2);
        chk("rst_mispred", 32'(mispredicted_mem), 0);
        chk("rst_redirect", redirect_pc_mem, 0);
        chk("rst_upd_valid", 32'(btb_upd_valid), 0);
        chk("rst_upd_pc", btb_upd_pc, 0);
        chk("rst_full", 32'(upd_full), 0);
        chk("rst_mispred_cnt", 32'(mispred_cnt), 0);
        chk("rst_drop_cnt", 32'(drop_cnt), 0);
        rst = 1'b0;

        push_upd(32'h100, 32'h140, 1, 0);
        issue(1, K_BR, 0, 0, 0, 1, 32'h100, 32'h140, 32'h0, 1, 32'h140);
        idle(1);
        chk("beq_upd_valid", 32'(btb_upd_valid), 1);
        chk("beq_upd_pc", btb_upd_pc, 32'h100);
        chk("beq_mispred_cnt", 32'(mispred_cnt), 1);

        push_upd(32'h200, 32'h304, 1, 1);
        issue(1, K_JALR, 0, 1, 1, 0, 32'h200, 32'h304, 32'h300, 1, 32'h304);
        issue(1, K_JALR, 0, 7, 1, 0, 32'h210, 32'h400, 32'h400, 0, 0);
        push_upd(32'h220, 32'h500, 1, 0);
        issue(1, K_JAL, 1, 0, 1, 0, 32'h220, 32'h500, 32'h500, 0, 0);
        push_upd(32'hFFFF_FFFC, 32'h80, 0, 0);
        issue(1, K_BR, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'h80, 32'h80, 1, 32'h0);
        push_upd(32'h230, 32'h260, 0, 0);
        issue(1, K_BR, 0, 0, 0, 0, 32'h230, 32'h260, 32'h0, 0, 0);
        issue(1, K_NONE, 0, 0, 1, 1, 32'h240, 32'h999, 32'h0, 0, 0);
        issue(0, K_BR, 0, 0, 0, 1, 32'h250, 32'h290, 32'h0, 0, 0);
        idle(3);
        chk("dir_mispred_cnt", 32'(mispred_cnt), 3);
        chk("dir_drop_cnt", 32'(drop_cnt), 0);

        btb_upd_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            pc = 32'h1000 + 32'(16 * i);
            if (i < DEPTH) push_upd(pc, pc + 32'h100, 1, 0);
            issue(1, K_BR, 0, 0, 1, 1, pc, pc + 32'h100, pc + 32'h100, 0, 0);
            if (i == DEPTH - 1) begin
                idle(1);
                chk("fill_full", 32'(upd_full), 1);
                chk("fill_drop0", 32'(drop_cnt), 0);
                chk("fill_head_held", btb_upd_pc, 32'h1000);
            end
        end
        idle(1);
        chk("fill_drop2", 32'(drop_cnt), 2);
        chk("fill_full_still", 32'(upd_full), 1);
        btb_upd_ready = 1'b1;
        idle(6);
        chk("drain_valid", 32'(btb_upd_valid), 0);
        chk("drain_pc_zero", btb_upd_pc, 0);
        chk("drain_full", 32'(upd_full), 0);

        btb_upd_ready = 1'b0;
        push_upd(32'h400, 32'h480, 1, 0);
        issue(1, K_BR, 0, 0, 1, 1, 32'h400, 32'h480, 32'h480, 0, 0);
        issue(1, K_BR, 0, 0, 1, 0, 32'h400, 32'h480, 32'h480, 1, 32'h404);
        issue(1, K_BR, 0, 0, 1, 1, 32'h400, 32'h480, 32'h480, 0, 0);
        idle(1);
        chk("coal_full", 32'(upd_full), 0);
        chk("coal_taken", 32'(btb_upd_taken), 1);
        btb_upd_ready = 1'b1;
        idle(3);
        chk("coal_single", 32'(btb_upd_valid), 0);

        btb_upd_ready = 1'b0;
        push_upd(32'h600, 32'h680, 1, 0);
        push_upd(32'h600, 32'h680, 0, 0);
        issue(1, K_BR, 0, 0, 1, 1, 32'h600, 32'h680, 32'h680, 0, 0);
        issue(1, K_BR, 0, 0, 0, 0, 32'h600, 32'h680, 32'h0, 0, 0);
        btb_upd_ready = 1'b1;
        idle(4);
        chk("popcoal_empty", 32'(btb_upd_valid), 0);

        btb_upd_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            pc = 32'h2000 + 32'(16 * i);
            push_upd(pc, pc + 32'h40, 1, 0);
            issue(1, K_BR, 0, 0, 1, 1, pc, pc + 32'h40, pc + 32'h40, 0, 0);
        end
        push_upd(32'h2100, 32'h2140, 1, 0);
        issue(1, K_BR, 0, 0, 1, 1, 32'h2100, 32'h2140, 32'h2140, 0, 0);
        btb_upd_ready = 1'b1;
        idle(1);
        btb_upd_ready = 1'b0;
        chk("pp_full", 32'(upd_full), 1);
        chk("pp_drop", 32'(drop_cnt), 2);
        chk("pp_head", btb_upd_pc, 32'h2010);
        btb_upd_ready = 1'b1;
        idle(6);
        chk("pp_drained", 32'(btb_upd_valid), 0);

        for (int i = 0; i < 14; i++)
            issue(1, K_JALR, 1, 2, 0, 0, 32'h3000 + 32'(4 * i), 32'h3800, 32'h0, 1, 32'h3800);
        idle(2);
        chk("sat_mispred_cnt", 32'(mispred_cnt), 15);

        btb_upd_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            pc = 32'h5000 + 32'(8 * i);
            if (i < DEPTH) push_upd(pc, pc + 32'h20, 1, 0);
            issue(1, K_BR, 0, 0, 1, 1, pc, pc + 32'h20, pc + 32'h20, 0, 0);
        end
        idle(2);
        chk("sat_drop_cnt", 32'(drop_cnt), 15);
        chk("sat_full", 32'(upd_full), 1);

        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        upd_q.delete();
        chk("mrst_upd_valid", 32'(btb_upd_valid), 0);
        chk("mrst_full", 32'(upd_full), 0);
        chk("mrst_mispred_cnt", 32'(mispred_cnt), 0);
        chk("mrst_drop_cnt", 32'(drop_cnt), 0);
        chk("mrst_upd_pc", btb_upd_pc, 0);

        btb_upd_ready = 1'b1;
        push_upd(32'h700, 32'h740, 1, 0);
        issue(1, K_BR, 0, 0, 0, 1, 32'h700, 32'h740, 32'h0, 1, 32'h740);
        idle(3);
        chk("post_mispred_cnt", 32'(mispred_cnt), 1);
        chk("mis_q_empty", 32'(mis_q.size()), 0);
        chk("upd_q_empty", 32'(upd_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
